decereal: RTL and testbench

Serial receiver for the cereal link: deserializes the one-wire frame stream that the cereal transmitter drives, for example on `out_fin`, back into 8-bit bytes. It oversamples the line on `sysclk`, validates start and stop bits, and presents each received byte with a one-cycle strobe. It sits at the far end of the link and feeds whatever consumes the byte stream, such as a loopback checker or a display latch.

---
 rtl/decereal.sv | 176 +++++++++++++++++
 tb/tb_decereal.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/decereal.sv
// decereal: oversampling serial receiver for the cereal link (start, 8 data bits LSB first, stop).
// Define DECEREAL_PARITY_EN to add an even-parity bit after the data bits and the parity_err port.
module decereal #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       sysclk,
   input  logic       reset_n,
   input  logic       cereal_in,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy,
`ifdef DECEREAL_PARITY_EN
   output logic       parity_err,
`endif
   output logic [2:0] state_dbg
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
`ifdef DECEREAL_PARITY_EN
      PARITY    = 3'd5,
`endif
      WAIT_HIGH = 3'd4
   } state_t;

   state_t          state, state_next;
   logic            sync1, sync2, sync_prev;
   logic [CW-1:0]   cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shreg;
   logic            fall, line, cnt_done;
   logic            cnt_clr, shift_en, load_en, ferr_set;
`ifdef DECEREAL_PARITY_EN
   logic            par_bit, par_en, perr_set;
`endif

   // Synchronizer and previous-value flops idle high so reset never looks like a start edge.
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         sync_prev <= 1'b1;
      end else begin
         sync1     <= cereal_in;
         sync2     <= sync1;
         sync_prev <= sync2;
      end
   end

   assign line     = sync2;
   assign fall     = sync_prev & ~sync2;
   assign cnt_done = (state == START) ? (cnt == HALF_M1) : (cnt == FULL_M1);

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      cnt_clr    = 1'b0;
      shift_en   = 1'b0;
      load_en    = 1'b0;
      ferr_set   = 1'b0;
`ifdef DECEREAL_PARITY_EN
      par_en     = 1'b0;
      perr_set   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (fall) begin
               cnt_clr    = 1'b1;
               state_next = START;
            end
         end
         START: begin
            if (cnt_done) begin
               cnt_clr    = 1'b1;
               state_next = line ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_done) begin
               cnt_clr  = 1'b1;
               shift_en = 1'b1;
               if (bit_idx == 3'd7) begin
`ifdef DECEREAL_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end
            end
         end
`ifdef DECEREAL_PARITY_EN
         PARITY: begin
            if (cnt_done) begin
               cnt_clr    = 1'b1;
               par_en     = 1'b1;
               state_next = STOP;
            end
         end
`endif
         STOP: begin
            if (cnt_done) begin
               cnt_clr = 1'b1;
               if (line) begin
                  load_en    = 1'b1;
`ifdef DECEREAL_PARITY_EN
                  perr_set   = par_bit ^ (^shreg);
`endif
                  state_next = IDLE;
               end else begin
                  ferr_set   = 1'b1;
                  state_next = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            if (line) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath: bit timing counter, shift register and registered output pulses.
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         cnt       <= '0;
         bit_idx   <= 3'd0;
         shreg     <= 8'h00;
         data      <= 8'h00;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (cnt_clr)
            cnt <= '0;
         else if (state != IDLE && state != WAIT_HIGH)
            cnt <= cnt + 1'b1;
         if (state == START)
            bit_idx <= 3'd0;
         else if (shift_en)
            bit_idx <= bit_idx + 3'd1;
         if (shift_en)
            shreg <= {line, shreg[7:1]};
         if (load_en)
            data <= shreg;
         valid     <= load_en;
         frame_err <= ferr_set;
      end
   end

`ifdef DECEREAL_PARITY_EN
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         if (par_en) par_bit <= line;
         parity_err <= perr_set;
      end
   end
`endif

   assign busy      = (state != IDLE);
   assign state_dbg = state;

endmodule

// File: tb/tb_decereal.sv
// Directed bench for decereal: frames are driven bit by bit, expected results queued and
// compared by a monitor when valid/frame_err/parity_err pulse.
module tb_decereal;

   localparam int CPB = 8;
`ifdef DECEREAL_PARITY_EN
   localparam bit PAR_ON = 1'b1;
`else
   localparam bit PAR_ON = 1'b0;
`endif

   logic       sysclk = 1'b0;
   logic       reset_n = 1'b0;
   logic       cereal_in = 1'b1;
   logic [7:0] data;
   logic       valid, frame_err, busy;
   logic [2:0] state_dbg;
   logic       perr_obs;
`ifdef DECEREAL_PARITY_EN
   logic       parity_err;
   assign perr_obs = parity_err;
`else
   assign perr_obs = 1'b0;
`endif

   decereal #(.CLKS_PER_BIT(CPB)) dut (
      .sysclk    (sysclk),
      .reset_n   (reset_n),
      .cereal_in (cereal_in),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy),
`ifdef DECEREAL_PARITY_EN
      .parity_err(parity_err),
`endif
      .state_dbg (state_dbg)
   );

   always #5 sysclk = ~sysclk;

   // Entry layout: {parity_err, frame_err, data}
   logic [9:0] exp_q[$];
   int         errors = 0;
   int         checks = 0;
   logic [7:0] last_data = 8'h00;
   logic       prev_pulse = 1'b0;
   bit         b2b_on = 1'b0;
   int         low_run = 0;
   int         max_gap = 0;

   always @(negedge sysclk) begin
      logic [9:0] got, exp;
      if (reset_n) begin
         if (valid || frame_err || perr_obs) begin
            got = {perr_obs, frame_err, data};
            checks++;
            assert (!(valid && frame_err) && !prev_pulse) else begin
               errors++;
               $error("FAIL pulse_shape valid=%0b frame_err=%0b prev_high=%0b required single-cycle exclusive",
                      valid, frame_err, prev_pulse);
            end
            checks++;
            assert (exp_q.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_output got=%h required no output", got);
            end
            if (exp_q.size() != 0) begin
               exp = exp_q.pop_front();
               checks++;
               assert (got === exp) else begin
                  errors++;
                  $error("FAIL output {perr,ferr,data} got=%h required %h", got, exp);
               end
            end
         end
         prev_pulse = valid || frame_err || perr_obs;
         if (b2b_on) begin
            if (!busy) low_run++;
            else begin
               if (low_run > max_gap) max_gap = low_run;
               low_run = 0;
            end
         end
      end else begin
         prev_pulse = 1'b0;
      end
   end

   task automatic send_bit(input logic b);
      cereal_in = b;
      repeat (CPB) @(negedge sysclk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_ok, input logic par_ok);
      logic pbit;
      if (stop_ok) begin
         exp_q.push_back({PAR_ON & ~par_ok, 1'b0, b});
         last_data = b;
      end else begin
         exp_q.push_back({1'b0, 1'b1, last_data});
      end
      pbit = par_ok ? ^b : ~(^b);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      if (PAR_ON) send_bit(pbit);
      send_bit(stop_ok);
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s got=%0b required %0b", tag, obs, req);
      end
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 20 * CPB && exp_q.size() != 0; i++) @(negedge sysclk);
      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL %s pending_outputs got=%0d required 0", tag, exp_q.size());
      end
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge sysclk);
      checks++;
      assert (data === 8'h00) else begin
         errors++; $error("FAIL reset_data got=%h required 00", data);
      end
      check_bit("reset_valid", valid, 1'b0);
      check_bit("reset_frame_err", frame_err, 1'b0);
      check_bit("reset_busy", busy, 1'b0);
      check_bit("reset_perr", perr_obs, 1'b0);
      reset_n = 1'b1;
      repeat (5) @(negedge sysclk);

      // Single frame
      send_frame(8'hA5, 1'b1, 1'b1);
      drain("single_a5");

      // Back-to-back frames; busy only drops between the mid-stop sample and the next start edge
      repeat (4) @(negedge sysclk);
      low_run = 0; max_gap = 0; b2b_on = 1'b1;
      send_frame(8'h00, 1'b1, 1'b1);
      send_frame(8'hFF, 1'b1, 1'b1);
      send_frame(8'h3C, 1'b1, 1'b1);
      b2b_on = 1'b0;
      drain("b2b");
      checks++;
      assert (max_gap <= CPB / 2 + 4) else begin
         errors++; $error("FAIL b2b_busy_gap got=%0d required <=%0d", max_gap, CPB / 2 + 4);
      end

      // Bad stop bit, line stuck low, then released
      send_frame(8'h55, 1'b0, 1'b1);
      cereal_in = 1'b0;
      repeat (40) @(negedge sysclk);
      check_bit("stuck_low_busy", busy, 1'b1);
      cereal_in = 1'b1;
      repeat (6) @(negedge sysclk);
      drain("frame_err");
      check_bit("after_break_busy", busy, 1'b0);

      // Start glitch
      cereal_in = 1'b0;
      repeat (2) @(negedge sysclk);
      cereal_in = 1'b1;
      repeat (3 * CPB) @(negedge sysclk);
      check_bit("glitch_busy", busy, 1'b0);
      send_frame(8'h81, 1'b1, 1'b1);
      drain("after_glitch_81");

      // Reset during the 4th data bit of 0xC3
      send_bit(1'b0);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      cereal_in = 1'b0;
      repeat (3) @(negedge sysclk);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      assert (data === 8'h00) else begin
         errors++; $error("FAIL midreset_data got=%h required 00", data);
      end
      check_bit("midreset_busy", busy, 1'b0);
      check_bit("midreset_valid", valid, 1'b0);
      check_bit("midreset_frame_err", frame_err, 1'b0);
      last_data = 8'h00;
      cereal_in = 1'b1;
      repeat (4) @(negedge sysclk);
      reset_n = 1'b1;
      repeat (4) @(negedge sysclk);
      send_frame(8'h7E, 1'b1, 1'b1);
      drain("after_reset_7e");

      // Wrong parity bit; only transmitted when parity is built in
      if (PAR_ON) begin
         send_frame(8'h07, 1'b1, 1'b0);
         drain("bad_parity_07");
      end

      repeat (5) @(negedge sysclk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
